// File: rtl/myproject_pkg.sv
// Shared definitions for the LSTM gate lanes: FSM encoding, output limits and the
// default-format rescale/saturate helper.
package myproject_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Default lane format: 32-bit accumulator, ap_fixed<16,6> result, 10-bit rescale.
   localparam int ACC_W  = 32;
   localparam int OUT_W  = 16;
   localparam int FRAC_W = 10;

   localparam logic [OUT_W-1:0] OUT_MAX = 16'h7FFF;
   localparam logic [OUT_W-1:0] OUT_MIN = 16'h8000;

   typedef struct packed {
      logic [OUT_W-1:0] val;
      logic             clip;
   } sat_res_t;

   // Floor-rescale the accumulator and clip into the signed output range.
   function automatic sat_res_t sat_trunc(input logic [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] shifted;
      sat_res_t                r;
      shifted = $signed(acc) >>> FRAC_W;
      r.val   = shifted[OUT_W-1:0];
      r.clip  = 1'b0;
      if (shifted[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){shifted[ACC_W-1]}}) begin
         r.clip = 1'b1;
         r.val  = shifted[ACC_W-1] ? OUT_MIN : OUT_MAX;
      end
      return r;
   endfunction

endpackage

// File: rtl/myproject_sat_trunc.sv
// Combinational rescale (arithmetic shift, floor) and saturation of a wide signed sum
// into the signed output format, with a clip indication.
module myproject_sat_trunc
   import myproject_pkg::*;
#(
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int FRAC_SHIFT = 10
) (
   input  logic [ACC_WIDTH-1:0] acc,
   output logic [OUT_WIDTH-1:0] dout,
   output logic                 clip
);

   generate
      if (ACC_WIDTH == ACC_W && OUT_WIDTH == OUT_W && FRAC_SHIFT == FRAC_W) begin : g_default
         sat_res_t res;
         always_comb begin
            res  = sat_trunc(acc);
            dout = res.val;
            clip = res.clip;
         end
      end else begin : g_generic
         localparam logic [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
         localparam logic [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};
         logic signed [ACC_WIDTH-1:0] shifted;
         // Everything above the output sign bit must be a copy of it, else the value clips.
         always_comb begin
            shifted = $signed(acc) >>> FRAC_SHIFT;
            dout    = shifted[OUT_WIDTH-1:0];
            clip    = 1'b0;
            if (shifted[ACC_WIDTH-1:OUT_WIDTH-1] !=
                {(ACC_WIDTH-OUT_WIDTH+1){shifted[ACC_WIDTH-1]}}) begin
               clip = 1'b1;
               dout = shifted[ACC_WIDTH-1] ? MIN_V : MAX_V;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/myproject_dot_accum.sv
// Gate-lane dot-product accumulator: sums N_TERMS signed products plus a bias, rescales
// and saturates the sum, and offers it to the activation stage.
module myproject_dot_accum
   import myproject_pkg::*;
#(
   parameter int PROD_WIDTH = 26,
   parameter int ACC_WIDTH  = 32,
   parameter int N_TERMS    = 16,
   parameter int OUT_WIDTH  = 16,
   parameter int FRAC_SHIFT = 10
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [PROD_WIDTH-1:0] prod_data,
   input  logic                  prod_vld,
   input  logic                  prod_last,
   output logic                  prod_rdy,
   input  logic [OUT_WIDTH-1:0]  bias,
   output logic [OUT_WIDTH-1:0]  dout,
   output logic                  dout_vld,
   input  logic                  dout_rdy,
   output logic                  sat_flag,
   output logic                  last_err,
   output logic                  dbg_state
);

   localparam int CW = $clog2(N_TERMS);
   localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [ACC_WIDTH-1:0]   acc;
   logic [ACC_WIDTH-1:0]   base;
   logic [ACC_WIDTH-1:0]   sum;
   logic [OUT_WIDTH-1:0]   sat_dout;
   logic                   sat_clip;
   logic                   accept;
   logic                   is_last;

   // Handshakes: a term moves when prod_vld && prod_rdy at a rising edge; a result moves
   // when dout_vld && dout_rdy. Once raised, dout_vld and its payload hold until taken.
   // While a result is held, the next vector's first term may only enter together with
   // the result leaving, so prod_rdy follows dout_rdy in HOLD.
   assign prod_rdy  = (state == ST_ACCUM) || dout_rdy;
   assign accept    = prod_vld && prod_rdy;
   assign is_last   = (cnt == LAST_CNT);
   assign dbg_state = state;

   // The first term of a vector starts from the bias aligned to the product's fraction.
   always_comb begin
      base = acc;
      if (cnt == '0) begin
         base = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias} << FRAC_SHIFT;
      end
      sum = base + {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
   end

   myproject_sat_trunc #(
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_sat_trunc (
      .acc  (sum),
      .dout (sat_dout),
      .clip (sat_clip)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state    <= ST_ACCUM;
         cnt      <= '0;
         acc      <= '0;
         dout     <= '0;
         dout_vld <= 1'b0;
         sat_flag <= 1'b0;
         last_err <= 1'b0;
      end else begin
         if (state == ST_HOLD && dout_rdy) begin
            dout_vld <= 1'b0;
            state    <= ST_ACCUM;
         end
         if (accept) begin
            acc <= sum;
            // prod_last is only cross-checked; the term count alone closes a vector.
            if (prod_last != is_last) begin
               last_err <= 1'b1;
            end
            if (is_last) begin
               dout     <= sat_dout;
               dout_vld <= 1'b1;
               sat_flag <= sat_clip;
               cnt      <= '0;
               state    <= ST_HOLD;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule
